// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_addsub
// Brief    : Add/subtract WIDTH-bit operands DIGIT bits per clock through one
//            ripple slice. Valid/ready handshakes on the input and output sides.
// Revision : 1.0
// ============================================================================
module digit_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_N  = WIDTH / DIGIT;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic [c_CW-1:0]   cnt_q;
    logic              carry_q, cout_q, ovf_q, zero_q;
    logic              in_ready_q, out_valid_q;

    logic [c_IW-1:0]   w_base;
    logic [DIGIT-1:0]  w_a_dig, w_b_dig;
    logic [DIGIT:0]    w_slice;
    logic              w_c_msb;
    logic [WIDTH-1:0]  w_sum_d;

    assign w_base  = c_IW'(32'(cnt_q) * 32'(DIGIT));
    assign w_a_dig = a_q[w_base +: DIGIT];
    assign w_b_dig = b_q[w_base +: DIGIT];
    assign w_slice = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the slice MSB, recovered from the MSB sum bit.
    assign w_c_msb = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_slice[DIGIT-1];

    always_comb begin
        w_sum_d = sum_q;
        w_sum_d[w_base +: DIGIT] = w_slice[DIGIT-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1; borrow-in flips the +1.
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{sub}};
                        carry_q    <= cin ^ sub;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= w_sum_d;
                    carry_q <= w_slice[DIGIT];
                    if (cnt_q == c_LAST) begin
                        cout_q      <= w_slice[DIGIT];
                        ovf_q       <= w_c_msb ^ w_slice[DIGIT];
                        zero_q      <= (w_sum_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + c_CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire
